// File: rtl/ps2_scan_rx_pkg.sv
// rtl/ps2_scan_rx_pkg.sv - shared constants, types and helpers for the PS/2 scan receiver
// Contents: prefix byte values, frame length, FIFO entry type, receive FSM states,
// odd-parity helper. No ports.
package ps2_scan_rx_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_t;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - two-flop synchroniser followed by a run-length deglitch filter
// Ports: clk, rst (sync, active-high), line_i (raw asynchronous pin),
//        line_o (filtered level, idles high).
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronised samples that disagree with the
    // filtered level; the level flips on the FILTER_LEN-th such sample.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard receive front end with prefix folding and event FIFO
// Ports: clk, rst (sync, active-high); ps2_clk/ps2_data raw pins; out_code/out_release/
// out_extended/out_valid/out_ready head-of-FIFO handshake; fifo_count occupancy;
// err_parity/err_frame one-cycle pulses; overflow/reset_required sticky flags.
// Build option: define PS2_SCAN_RX_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module ps2_scan_rx
    import ps2_scan_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic [7:0]                  out_code,
    output logic                        out_release,
    output logic                        out_extended,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        overflow,
    output logic                        reset_required
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_scan_rx: invalid parameter set");
    end

    logic fclk, fdata, fclk_prev_q, clk_fall, to_expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .rst(rst), .line_i(ps2_clk), .line_o(fclk)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk(clk), .rst(rst), .line_i(ps2_data), .line_o(fdata)
    );

    assign clk_fall = fclk_prev_q & ~fclk;

    ps2_state_t state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [9:0] shreg_q, shreg_d;   // bits 1..10 of the frame, bit 1 at index 0
    logic       ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
    logic       push;
    ps2_event_t push_entry;

`ifdef PS2_SCAN_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_SHIFT || clk_fall) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_expired = (state_q == ST_SHIFT) && !clk_fall &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        bitcnt_d            = bitcnt_q;
        shreg_d             = shreg_q;
        ext_pend_d          = ext_pend_q;
        rel_pend_d          = rel_pend_q;
        err_frame           = 1'b0;
        err_parity          = 1'b0;
        push                = 1'b0;
        push_entry.extended = ext_pend_q;
        push_entry.released = rel_pend_q;
        push_entry.code     = shreg_q[7:0];
        case (state_q)
            ST_IDLE: begin
                // A falling edge with data high is not a start bit; stay idle.
                if (clk_fall && !fdata) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = 4'd1;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    shreg_d  = {fdata, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (to_expired) begin
                    state_d    = ST_IDLE;
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!shreg_q[9]) begin
                    err_frame  = 1'b1;
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end else if (!odd_parity_ok(shreg_q[8:0])) begin
                    err_parity = 1'b1;
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end else if (shreg_q[7:0] == PS2_PREFIX_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (shreg_q[7:0] == PS2_PREFIX_REL) begin
                    rel_pend_d = 1'b1;
                end else begin
                    push       = 1'b1;
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
            fclk_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            ext_pend_q  <= ext_pend_d;
            rel_pend_q  <= rel_pend_d;
            fclk_prev_q <= fclk;
        end
    end

    // Event FIFO. A simultaneous pop frees the slot, so a push into a full
    // FIFO is only dropped when nothing leaves in the same cycle.
    ps2_event_t    mem_q [FIFO_DEPTH];
    ps2_event_t    head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q, reset_req_q, full, pop, push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    assign push_ok = push & (!full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            reset_req_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (err_frame || err_parity || (push && !push_ok)) begin
                reset_req_q <= 1'b1;
            end
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign out_code       = head.code;
    assign out_release    = head.released;
    assign out_extended   = head.extended;
    assign out_valid      = (count_q != '0);
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign reset_required = reset_req_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - self-checking bench for ps2_scan_rx
module tb_ps2_scan_rx;
    localparam int DEPTH = 4;
    localparam int FLEN  = 4;
    localparam int TOUT  = 300;
    localparam int QTR   = 10;
    localparam int HALF  = 20;
    localparam int GAP   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic out_ready = 1'b0;
    logic [7:0] out_code;
    logic out_release, out_extended, out_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic err_parity, err_frame, overflow, reset_required;

    int checks = 0;
    int errors = 0;
    int mon_perr = 0;
    int mon_ferr = 0;
    int perr0 = 0;
    int ferr0 = 0;

    // Reference model state: expected FIFO contents {ext, rel, code}.
    logic [9:0] exp_q[$];
    bit m_ext, m_rel, m_ovf, m_rr;
    int m_perr, m_ferr;

    ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_code(out_code), .out_release(out_release), .out_extended(out_extended),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow),
        .reset_required(reset_required)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity === 1'b1) mon_perr <= mon_perr + 1;
        if (err_frame === 1'b1) mon_ferr <= mon_ferr + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            m_ferr++; m_rr = 1; m_ext = 0; m_rel = 0;
        end else if (bad_par) begin
            m_perr++; m_rr = 1; m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_rel, b});
            else begin m_ovf = 1; m_rr = 1; end
            m_ext = 0; m_rel = 0;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        exp_q.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0; m_rr = 0; m_perr = 0; m_ferr = 0;
        perr0 = mon_perr; ferr0 = mon_ferr;
    endtask

    // mode 0: plain; mode 1: measure stop-edge to out_valid latency;
    // mode 2: pulse out_ready for the push cycle of this frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int mode, input int nbits,
                              output int lat, output logic [9:0] seen);
        logic [10:0] bits;
        int k;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lat = -1;
        seen = '0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                tick(3); ps2_clk = 1'b0; tick(FLEN - 1); ps2_clk = 1'b1; tick(QTR - 3 - (FLEN - 1));
            end else begin
                tick(QTR);
            end
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                k = 0;
                while (k < HALF && out_valid !== 1'b1) begin tick(1); k++; end
                lat = k;
                tick(HALF - k);
            end else if (i == 10 && mode == 2) begin
                tick(7);
                seen = {out_extended, out_release, out_code};
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                tick(HALF - 8);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
            tick(QTR);
        end
        if (nbits == 11) model_frame(b, bad_par, bad_stop);
        tick(GAP);
    endtask

    task automatic drain(input string tag);
        int guard;
        logic [9:0] head;
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            guard++;
            if (out_valid === 1'b1) begin
                head = {out_extended, out_release, out_code};
                checks++;
                if (head !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s head: got %h expected %h", tag, head, exp_q[0]);
                end
                if ($urandom_range(0, 1) == 1) begin
                    out_ready = 1'b1;
                    void'(exp_q.pop_front());
                end else begin
                    out_ready = 1'b0;
                end
            end else begin
                out_ready = 1'b0;
            end
            tick(1);
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d entries never appeared, expected 0", tag, exp_q.size());
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL %s empty: got valid=%b count=%0d expected valid=0 count=0", tag, out_valid, fifo_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_code !== 8'h00) begin errors++; $display("FAIL reset out_code: got %h expected 00", out_code); end
        checks++; if ({out_release, out_extended, out_valid} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {out_release, out_extended, out_valid}); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset fifo_count: got %0d expected 0", fifo_count); end
        checks++; if ({err_parity, err_frame} !== 2'b00) begin errors++; $display("FAIL reset err: got %b expected 00", {err_parity, err_frame}); end
        checks++; if ({overflow, reset_required} !== 2'b00) begin errors++; $display("FAIL reset sticky: got %b expected 00", {overflow, reset_required}); end
    endtask

    task automatic test_single();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'h1C, 0, 0, -1, 1, 11, lat, seen);
        checks++; if (lat != 2 + FLEN + 2) begin errors++; $display("FAIL single latency: got %0d expected %0d", lat, 2 + FLEN + 2); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single count: got %0d expected 1", fifo_count); end
        checks++; if (mon_perr - perr0 != 0 || mon_ferr - ferr0 != 0) begin errors++; $display("FAIL single pulses: got %0d/%0d expected 0/0", mon_perr - perr0, mon_ferr - ferr0); end
        drain("single");
    endtask

    task automatic test_prefix();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'hE0, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'hF0, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'h75, 0, 0, -1, 0, 11, lat, seen);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL prefix count: got %0d expected 1", fifo_count); end
        checks++; if ({out_extended, out_release, out_code} !== 10'h375) begin errors++; $display("FAIL prefix head: got %h expected 375", {out_extended, out_release, out_code}); end
        drain("prefix");
    endtask

    task automatic test_errors();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'h1C, 1, 0, -1, 0, 11, lat, seen);
        checks++; if (mon_perr - perr0 != 1 || mon_ferr - ferr0 != 0) begin errors++; $display("FAIL parity pulses: got %0d/%0d expected 1/0", mon_perr - perr0, mon_ferr - ferr0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL parity entry: got valid=%b expected 0", out_valid); end
        checks++; if (reset_required !== 1'b1) begin errors++; $display("FAIL parity sticky: got %b expected 1", reset_required); end
        send_frame(8'h1C, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'h22, 1, 1, -1, 0, 11, lat, seen);
        checks++; if (mon_perr - perr0 != m_perr || mon_ferr - ferr0 != m_ferr) begin errors++; $display("FAIL stop priority: got %0d/%0d expected %0d/%0d", mon_perr - perr0, mon_ferr - ferr0, m_perr, m_ferr); end
        checks++; if (reset_required !== 1'b1) begin errors++; $display("FAIL sticky hold: got %b expected 1", reset_required); end
        drain("errors");
        do_reset();
        checks++; if (reset_required !== 1'b0) begin errors++; $display("FAIL sticky clear: got %b expected 0", reset_required); end
    endtask

`ifdef PS2_SCAN_RX_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'hE0, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'h5A, 0, 0, -1, 0, 5, lat, seen);
        tick(TOUT + 50);
        m_ext = 0; m_rel = 0;
        send_frame(8'h29, 0, 0, -1, 0, 11, lat, seen);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL timeout count: got %0d expected 1", fifo_count); end
        checks++; if (mon_perr - perr0 != 0 || mon_ferr - ferr0 != 0) begin errors++; $display("FAIL timeout pulses: got %0d/%0d expected 0/0", mon_perr - perr0, mon_ferr - ferr0); end
        drain("timeout");
    endtask
`endif

    task automatic test_overflow();
        int lat; logic [9:0] seen;
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
        do_reset();
        foreach (codes[i]) send_frame(codes[i], 0, 0, -1, 0, 11, lat, seen);
        checks++; if ({overflow, reset_required} !== 2'b11) begin errors++; $display("FAIL overflow flags: got %b expected 11", {overflow, reset_required}); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL overflow count: got %0d expected 4", fifo_count); end
        drain("overflow");
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(codes[i], 0, 0, -1, 0, 11, lat, seen);
        send_frame(codes[4], 0, 0, -1, 2, 11, lat, seen);
        checks++; if (seen !== 10'h015) begin errors++; $display("FAIL pushpop head: got %h expected 015", seen); end
        checks++; if ({overflow, reset_required} !== 2'b00) begin errors++; $display("FAIL pushpop flags: got %b expected 00", {overflow, reset_required}); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL pushpop count: got %0d expected 4", fifo_count); end
        drain("pushpop");
    endtask

    task automatic test_glitch();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'h1C, 0, 0, 4, 0, 11, lat, seen);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL glitch count: got %0d expected 1", fifo_count); end
        checks++; if (mon_perr - perr0 != 0 || mon_ferr - ferr0 != 0) begin errors++; $display("FAIL glitch pulses: got %0d/%0d expected 0/0", mon_perr - perr0, mon_ferr - ferr0); end
        drain("glitch");
    endtask

    task automatic test_reset_mid_frame();
        int lat; logic [9:0] seen;
        do_reset();
        send_frame(8'h33, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'h44, 1, 0, -1, 0, 11, lat, seen);
        send_frame(8'hE0, 0, 0, -1, 0, 11, lat, seen);
        send_frame(8'h6B, 0, 0, -1, 0, 4, lat, seen);
        checks++; if ({reset_required, fifo_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL premid state: got rr=%b count=%0d expected rr=1 count=1", reset_required, fifo_count); end
        do_reset();
        checks++; if ({reset_required, out_valid, fifo_count, out_code} !== 13'h0) begin errors++; $display("FAIL midreset state: got rr=%b valid=%b count=%0d code=%h expected all 0", reset_required, out_valid, fifo_count, out_code); end
        send_frame(8'h1C, 0, 0, -1, 0, 11, lat, seen);
        drain("midreset");
    endtask

    task automatic test_random();
        int lat, n, sel; logic [9:0] seen; logic [7:0] b; bit bp, bs;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = $urandom_range(2, 7);
            for (int f = 0; f < n; f++) begin
                sel = $urandom_range(0, 15);
                b = 8'($urandom);
                if (sel < 3) b = 8'hE0;
                else if (sel < 6) b = 8'hF0;
                bs = (sel == 7);
                bp = (sel == 6) || (sel == 7 && $urandom_range(0, 1) == 1);
                send_frame(b, bp, bs, -1, 0, 11, lat, seen);
            end
            tick(4);
            checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL random count r%0d: got %0d expected %0d", r, fifo_count, exp_q.size()); end
            checks++; if ({overflow, reset_required} !== {m_ovf, m_rr}) begin errors++; $display("FAIL random sticky r%0d: got %b expected %b", r, {overflow, reset_required}, {m_ovf, m_rr}); end
            checks++; if (mon_perr - perr0 != m_perr || mon_ferr - ferr0 != m_ferr) begin errors++; $display("FAIL random pulses r%0d: got %0d/%0d expected %0d/%0d", r, mon_perr - perr0, mon_ferr - ferr0, m_perr, m_ferr); end
            drain("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_errors();
`ifdef PS2_SCAN_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_overflow();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Parametrised PS/2 keyboard receive front end: synchronises and deglitches `ps2_clk`/`ps2_data`, deframes 11-bit frames, checks start/parity/stop, folds `E0`/`F0` prefixes into flags and queues decoded scan events in a FIFO with a valid/ready output. It sits between the keyboard pins and the scan-code translation logic. It is the successor to the fixed-width single-latch keyboard receiver, adding buffering, glitch filtering, a frame timeout and error reporting.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal samples required before a filtered line changes; ≥1.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles mid-frame before the partial frame is discarded (2 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `out_code`  out  8  scan code of head entry.
- `out_release`  out  1  head entry was preceded by `F0`.
- `out_extended`  out  1  head entry was preceded by `E0`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `err_parity`  out  1  one-cycle pulse: parity failure.
- `err_frame`  out  1  one-cycle pulse: bad start or stop bit.
- `overflow`  out  1  sticky: event dropped because FIFO full.
- `reset_required`  out  1  sticky: any parity/frame error or overflow; host must reset keyboard.

## Operation
- Input path: 2-flop synchroniser per line, then filter: output takes new level after `FILTER_LEN` consecutive identical synchronised samples. Idle filtered level 1.
- Falling edge of filtered clock samples filtered data into bit counter 0..10, LSB first after start bit.
- States: `IDLE` → (edge, data=0) `SHIFT`; edge with data=1 in `IDLE` is ignored. `SHIFT` collects bits 1–9 (8 data, parity); bit 10 → `CHECK`. `CHECK` (one cycle): stop=1 and odd parity over data+parity → byte valid; else pulse matching error. Stop error takes priority over parity error (only `err_frame` pulses). Return to `IDLE`.
- Prefix decode on valid byte: `E0` sets ext_pend, `F0` sets rel_pend; neither pushed. Any other byte pushes {ext_pend, rel_pend, byte} and clears both pendings. Error frames and timeouts clear both pendings.
- FIFO: push when full → entry dropped, `overflow` and `reset_required` set. Push and pop in same cycle when full → both succeed, no overflow. Pop when empty impossible (`out_valid`=0).
- Outputs are registered from FIFO head; head stable while `out_valid & !out_ready`.
- `rst` mid-frame: abandon frame, clear pendings, empty FIFO, clear sticky flags.

## Timing
- Reset values: `out_code`=0, `out_release`=0, `out_extended`=0, `out_valid`=0, `fifo_count`=0, `err_parity`=0, `err_frame`=0, `overflow`=0, `reset_required`=0; filtered lines=1; state `IDLE`.
- Pin change to filtered change: 2+`FILTER_LEN` cycles.
- Filtered edge of stop bit (cycle N): `CHECK` at N+1, error pulse / push at N+1, `out_valid`=1 and `fifo_count` incremented at N+2.
- Pop at cycle M: next head or `out_valid`=0 at M+1.
- Timeout counter runs only in `SHIFT`, reset on every filtered falling edge; reaching `TIMEOUT_CYCLES` → `IDLE`, no error pulse.

## Configuration
- `PS2_SCAN_RX_TIMEOUT_EN` defined: timeout counter and abort as above.
- Not defined: counter removed; `SHIFT` waits indefinitely for edges; `TIMEOUT_CYCLES` unused.

## Structure
- Package `ps2_scan_rx_pkg`: constants `PS2_PREFIX_EXT`=8'hE0, `PS2_PREFIX_REL`=8'hF0, `PS2_FRAME_BITS`=11; typedef for FIFO entry {extended, release, code[7:0]}.
- Sub-module `ps2_line_filter` (synchroniser + `FILTER_LEN` filter), instantiated twice.

## Test plan
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) → one entry code=0x1C, release=0, extended=0; `out_valid` 2 cycles after stop edge.
- Bytes E0, F0, 75 → exactly one entry code=0x75, extended=1, release=1; `fifo_count`=1.
- Frame 0x1C with parity=1 → `err_parity` one-cycle pulse, no entry, `reset_required`=1 until `rst`.
- 5 bits then idle >`TIMEOUT_CYCLES` (macro defined), then frame 0x29 → single entry 0x29, no error pulses.
- `FIFO_DEPTH`=4, `out_ready`=0, frames 0x15,0x16,0x1E,0x26,0x25 → `overflow`=1, `fifo_count`=4, drain yields 0x15,0x16,0x1E,0x26.
- `ps2_clk` low glitch of `FILTER_LEN`-1 cycles during frame 0x1C → ignored, entry 0x1C received intact.
